// File: rtl/dmi_uart_resp_tx.sv
// DMI-over-UART response serialiser: turns one accepted request into
// HEADER, {cmd,addr}, LENGTH and LENGTH payload bytes (LSB first) on the UART byte port.
module dmi_uart_resp_tx #(
    parameter int unsigned IrLength = 5,
    parameter int unsigned DATA_W   = 41,
    parameter logic [7:0]  HEADER   = 8'h01
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [8-IrLength-1:0] req_cmd_i,
    input  logic [IrLength-1:0]   req_addr_i,
    input  logic [7:0]            req_len_i,
    input  logic [DATA_W-1:0]     req_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_we_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o
);

    localparam int unsigned CMD_W  = 8 - IrLength;
    localparam int unsigned NBYTES = (DATA_W + 7) / 8;
    localparam int unsigned PAD_W  = NBYTES * 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CMDADDR,
        ST_LENGTH,
        ST_DATA
    } state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [CMD_W-1:0]    r_cmd;
    logic [CMD_W-1:0]    w_cmd_d;
    logic [IrLength-1:0] r_addr;
    logic [IrLength-1:0] w_addr_d;
    logic [7:0]          r_len;
    logic [7:0]          w_len_d;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                r_tx_we;
    logic                w_tx_we_d;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_tx_data_d;

    logic                w_xfer;
    logic                w_last;
    logic [7:0]          w_len_clamp;

    // Payload byte idx; the zero padding clears the unused top bits of the remainder byte.
    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] data,
                                             input logic [CNT_W-1:0]  idx);
        logic [PAD_W-1:0] pad;
        pad = PAD_W'(data);
        return 8'(pad >> {idx, 3'b000});
    endfunction

    assign w_xfer      = r_tx_we && tx_ready_i;
    assign w_last      = (8'(r_cnt) == (r_len - 8'd1));
    assign w_len_clamp = (req_len_i > 8'(NBYTES)) ? 8'(NBYTES) : req_len_i;

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign tx_we_o     = r_tx_we;
    assign tx_data_o   = r_tx_data;

    // State, latched request and registered byte outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_tx_we   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cmd     <= w_cmd_d;
            r_addr    <= w_addr_d;
            r_len     <= w_len_d;
            r_data    <= w_data_d;
            r_cnt     <= w_cnt_d;
            r_tx_we   <= w_tx_we_d;
            r_tx_data <= w_tx_data_d;
        end
    end

    // Next state; the next byte is loaded on the same edge that retires the current one
    always_comb begin
        w_state_d   = r_state;
        w_cmd_d     = r_cmd;
        w_addr_d    = r_addr;
        w_len_d     = r_len;
        w_data_d    = r_data;
        w_cnt_d     = r_cnt;
        w_tx_we_d   = r_tx_we;
        w_tx_data_d = r_tx_data;

        unique case (r_state)
            ST_IDLE: begin
                w_tx_we_d = 1'b0;
                if (req_valid_i) begin
                    w_cmd_d     = req_cmd_i;
                    w_addr_d    = req_addr_i;
                    w_len_d     = w_len_clamp;
                    w_data_d    = req_data_i;
                    w_cnt_d     = '0;
                    w_state_d   = ST_HEADER;
                    w_tx_we_d   = 1'b1;
                    w_tx_data_d = HEADER;
                end
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    w_state_d   = ST_CMDADDR;
                    w_tx_data_d = {r_cmd, r_addr};
                end
            end
            ST_CMDADDR: begin
                if (w_xfer) begin
                    w_state_d   = ST_LENGTH;
                    w_tx_data_d = r_len;
                end
            end
            ST_LENGTH: begin
                if (w_xfer) begin
                    if (r_len == 8'd0) begin
                        w_state_d   = ST_IDLE;
                        w_tx_we_d   = 1'b0;
                        w_tx_data_d = '0;
                    end else begin
                        w_state_d   = ST_DATA;
                        w_cnt_d     = '0;
                        w_tx_data_d = pick_byte(r_data, '0);
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_d   = ST_IDLE;
                        w_cnt_d     = '0;
                        w_tx_we_d   = 1'b0;
                        w_tx_data_d = '0;
                    end else begin
                        w_cnt_d     = r_cnt + CNT_W'(1);
                        w_tx_data_d = pick_byte(r_data, r_cnt + CNT_W'(1));
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_tx_we_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmi_uart_resp_tx.sv
// Directed bench for dmi_uart_resp_tx: byte sequences, backpressure, clamping,
// back-to-back spacing and reset behaviour against hand-computed frames.
module tb_dmi_uart_resp_tx;

    logic        clk_i       = 1'b0;
    logic        rst_ni      = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_cmd_i   = '0;
    logic [4:0]  req_addr_i  = '0;
    logic [7:0]  req_len_i   = '0;
    logic [40:0] req_data_i  = '0;
    logic [7:0]  tx_data_o;
    logic        tx_we_o;
    logic        tx_ready_i  = 1'b1;
    logic        busy_o;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [40:0] DATA_A = 41'h1_2345_6789_AB;
    localparam logic [40:0] DATA_B = 41'h1FF_FFFF_BEEF;

    dmi_uart_resp_tx dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cmd_i   (req_cmd_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .req_data_i  (req_data_i),
        .tx_data_o   (tx_data_o),
        .tx_we_o     (tx_we_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] cmd, input logic [4:0] addr,
                        input logic [7:0] len, input logic [40:0] data, input bit hold);
        @(negedge clk_i);
        check("ready_before_req", 64'(req_ready_o), 64'd1);
        req_cmd_i   = cmd;
        req_addr_i  = addr;
        req_len_i   = len;
        req_data_i  = data;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        if (!hold) req_valid_i = 1'b0;
        check("busy_after_accept", 64'(busy_o), 64'd1);
    endtask

    // Collect n transfers starting at the current negedge; vec holds the bytes first-to-last.
    // mode 0: ready held high; mode 1: ready high one cycle in three.
    task automatic run_frame(input string tag, input logic [71:0] vec, input int n, input int mode);
        int         idx     = 0;
        int         first   = -1;
        int         last    = 0;
        int         budget  = 0;
        logic       stalled = 1'b0;
        logic [7:0] held    = '0;
        while (idx < n && budget < 200) begin
            tx_ready_i = (mode == 0) ? 1'b1 : ((budget % 3) == 2);
            if (stalled) begin
                check({tag, "_stall_we"}, 64'(tx_we_o), 64'd1);
                check({tag, "_stall_data"}, 64'(tx_data_o), 64'(held));
            end
            if (tx_we_o && tx_ready_i) begin
                check({tag, "_byte"}, 64'(tx_data_o), 64'(vec[8*(n-1-idx) +: 8]));
                if (first < 0) first = cyc;
                last    = cyc;
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = tx_we_o;
                held    = tx_data_o;
            end
            if (idx < n) begin
                @(negedge clk_i);
                budget++;
            end
        end
        tx_ready_i = 1'b1;
        check({tag, "_count"}, 64'(idx), 64'(n));
        if (mode == 0) check({tag, "_consecutive"}, 64'(last - first), 64'(n - 1));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk_i);
        check({tag, "_we"}, 64'(tx_we_o), 64'd0);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: outputs while in reset
        repeat (2) @(negedge clk_i);
        check("rst_we", 64'(tx_we_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_data", 64'(tx_data_o), 64'd0);
        rst_ni = 1'b1;
        expect_idle("post_rst");

        // T2: full frame, ready held high
        send(3'd2, 5'h11, 8'd6, DATA_A, 1'b0);
        run_frame("t2", 72'h01_51_06_AB_89_67_45_23_01, 9, 0);
        expect_idle("t2_end");

        // T3: same frame under backpressure
        send(3'd2, 5'h11, 8'd6, DATA_A, 1'b0);
        run_frame("t3", 72'h01_51_06_AB_89_67_45_23_01, 9, 1);
        expect_idle("t3_end");

        // T4: zero-length frame
        send(3'd0, 5'h01, 8'd0, DATA_A, 1'b0);
        run_frame("t4", 72'h01_01_00, 3, 0);
        expect_idle("t4_end");
        expect_idle("t4_end2");

        // T5: length request above the payload size is clamped
        send(3'd2, 5'h11, 8'd9, DATA_A, 1'b0);
        run_frame("t5", 72'h01_51_06_AB_89_67_45_23_01, 9, 0);
        expect_idle("t5_end");

        // T6: back-to-back with valid held; request inputs change during frame one
        send(3'd2, 5'h11, 8'd3, DATA_A, 1'b1);
        req_cmd_i  = 3'd7;
        req_addr_i = 5'h1F;
        req_len_i  = 8'd2;
        req_data_i = DATA_B;
        run_frame("t6a", 72'h01_51_03_AB_89_67, 6, 0);
        @(negedge clk_i);
        check("t6_gap_we", 64'(tx_we_o), 64'd0);
        check("t6_gap_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("t6_hdr_we", 64'(tx_we_o), 64'd1);
        check("t6_hdr_data", 64'(tx_data_o), 64'h01);
        run_frame("t6b", 72'h01_FF_02_EF_BE, 5, 0);
        expect_idle("t6_end");

        // T1b: reset in the middle of the data phase abandons the frame
        send(3'd2, 5'h11, 8'd6, DATA_A, 1'b0);
        repeat (5) @(negedge clk_i);
        check("mid_busy_before", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_we", 64'(tx_we_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd1);
        check("mid_rst_data", 64'(tx_data_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        expect_idle("mid_rst_release");
        expect_idle("mid_rst_release2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
